// File: rtl/cnn_sched_pkg.sv
// Shared types and constants for the CNN kernel batch scheduler and its stall watchdog.
package cnn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_t;

    localparam int DEF_RST_CYC    = 16;
    localparam int DEF_WDOG_LIMIT = 100000;
    localparam int MAX_INST       = 32;

    // Deadlock signature: kernel not idle, every instance idle or blocked, at least one blocked.
    // Callers pad unused idle bits with 1 and unused block bits with 0.
    function automatic logic deadlock_pattern(
        input logic [MAX_INST-1:0] idle_v,
        input logic [MAX_INST-1:0] block_v,
        input logic                k_idle
    );
        return ~k_idle & (&(idle_v | block_v)) & (|block_v);
    endfunction

endpackage

// File: rtl/cnn_sched_watchdog.sv
// Stall watchdog: counts consecutive deadlock-pattern cycles without kernel progress.
module cnn_sched_watchdog
    import cnn_sched_pkg::*;
#(
    parameter int NUM_INST   = 6,
    parameter int WDOG_W     = 20,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                enable,
    input  logic                clear,
    input  logic                progress,
    input  logic                k_ap_idle,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                expire
);

    localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [WDOG_W-1:0] CNT_MAX  = '1;

    logic [MAX_INST-1:0] idle_pad;
    logic [MAX_INST-1:0] block_pad;
    logic [WDOG_W-1:0]   cnt_reg;
    logic [WDOG_W-1:0]   cnt_next;
    logic                pattern;

    generate
        for (genvar gi = 0; gi < MAX_INST; gi++) begin : g_pad
            if (gi < NUM_INST) begin : g_used
                assign idle_pad[gi]  = inst_idle_sigs[gi];
                assign block_pad[gi] = inst_block_sigs[gi];
            end else begin : g_unused
                assign idle_pad[gi]  = 1'b1;
                assign block_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign pattern = enable & deadlock_pattern(idle_pad, block_pad, k_ap_idle);

    // Fires in the cycle whose increment would bring the count to the limit.
    assign expire = pattern & ~progress & (cnt_reg == LIMIT_M1);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear | ~pattern | progress) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/cnn_kernel_scheduler.sv
// Batch controller driving an ap_ctrl_chain kernel: issues/counts frames, aborts or
// soft-resets the kernel on host request or watchdog stall.
module cnn_kernel_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int NUM_INST    = 6,
    parameter int FRAME_CNT_W = 16,
    parameter int WDOG_W      = 20,
    parameter int WDOG_LIMIT  = DEF_WDOG_LIMIT,
    parameter int RST_CYC     = DEF_RST_CYC
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   cmd_start,
    input  logic                   cmd_abort,
    input  logic [FRAME_CNT_W-1:0] cfg_num_frames,
    output logic                   k_ap_start,
    input  logic                   k_ap_ready,
    input  logic                   k_ap_done,
    input  logic                   k_ap_idle,
    output logic                   k_ap_continue,
    input  logic [NUM_INST-1:0]    inst_idle_sigs,
    input  logic [NUM_INST-1:0]    inst_block_sigs,
    output logic                   busy,
    output logic                   done,
    output logic                   stall,
    output logic                   aborted,
    output logic [FRAME_CNT_W-1:0] frames_issued,
    output logic [FRAME_CNT_W-1:0] frames_done,
    output logic                   kernel_soft_rst
);

    localparam int             RST_W    = $clog2(RST_CYC + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);

    sched_state_t           state_reg,   state_next;
    logic [FRAME_CNT_W-1:0] target_reg,  target_next;
    logic [FRAME_CNT_W-1:0] issued_reg,  issued_next;
    logic [FRAME_CNT_W-1:0] fdone_reg,   fdone_next;
    logic [RST_W-1:0]       rst_cnt_reg, rst_cnt_next;
    logic                   done_reg,    done_next;
    logic                   stall_reg,   stall_next;
    logic                   aborted_reg, aborted_next;

    logic in_run;
    logic issue_acc;
    logic done_acc;
    logic final_done;
    logic wdog_expire;

    assign in_run     = (state_reg == ST_RUN);
    assign issue_acc  = k_ap_start & k_ap_ready;
    assign done_acc   = in_run & k_ap_done & (fdone_reg < target_reg);
    assign final_done = done_acc & ((fdone_reg + 1'b1) == target_reg);

    cnn_sched_watchdog #(
        .NUM_INST   (NUM_INST),
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .enable          (in_run),
        .clear           (state_next != ST_RUN),
        .progress        (issue_acc | done_acc),
        .k_ap_idle       (k_ap_idle),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .expire          (wdog_expire)
    );

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        issued_next  = issued_reg;
        fdone_next   = fdone_reg;
        rst_cnt_next = rst_cnt_reg;
        done_next    = 1'b0;
        stall_next   = stall_reg;
        aborted_next = aborted_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_start) begin
                    stall_next   = 1'b0;
                    aborted_next = 1'b0;
                    if (cfg_num_frames != '0) begin
                        state_next  = ST_RUN;
                        target_next = cfg_num_frames;
                        issued_next = '0;
                        fdone_next  = '0;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue_acc) issued_next = issued_reg + 1'b1;
                if (done_acc)  fdone_next  = fdone_reg + 1'b1;
                // Normal completion outranks a stall, which outranks a host abort.
                if (final_done) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (wdog_expire) begin
                    state_next   = ST_FLUSH;
                    stall_next   = 1'b1;
                    rst_cnt_next = '0;
                end else if (cmd_abort) begin
                    state_next   = ST_FLUSH;
                    aborted_next = 1'b1;
                    rst_cnt_next = '0;
                end
            end
            ST_FLUSH: begin
                if (rst_cnt_reg == RST_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_reg   <= ST_IDLE;
            target_reg  <= '0;
            issued_reg  <= '0;
            fdone_reg   <= '0;
            rst_cnt_reg <= '0;
            done_reg    <= 1'b0;
            stall_reg   <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            issued_reg  <= issued_next;
            fdone_reg   <= fdone_next;
            rst_cnt_reg <= rst_cnt_next;
            done_reg    <= done_next;
            stall_reg   <= stall_next;
            aborted_reg <= aborted_next;
        end
    end

    assign k_ap_start      = in_run & (issued_reg < target_reg);
    assign k_ap_continue   = (state_reg != ST_IDLE);
    assign busy            = (state_reg != ST_IDLE);
    assign kernel_soft_rst = (state_reg == ST_FLUSH);
    assign done            = done_reg;
    assign stall           = stall_reg;
    assign aborted         = aborted_reg;
    assign frames_issued   = issued_reg;
    assign frames_done     = fdone_reg;

endmodule
